// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller wrapped around the 16-bit SUM/SUB/MUL ALU, with an 8-entry register file.
// Optional zero_flag output when ALU_ISSUE_ZERO_FLAG_EN is defined.
module alu_issue_ctrl #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    input  logic [15:0]       instr,
    output logic              instr_ready,
    output logic [DATA_W-1:0] alu_data1,
    output logic [DATA_W-1:0] alu_data2,
    output logic [1:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_result,
    output logic              done,
    output logic [2:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    ,
    output logic              zero_flag
`endif
);

    localparam logic [1:0] OP_LDI = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        WB   = 2'b10
    } state_t;

    state_t            state_q;
    logic              ready_q;
    logic              done_q;
    logic [2:0]        rd_q;
    logic [2:0]        wb_addr_q;
    logic [DATA_W-1:0] wb_data_q;
    logic [DATA_W-1:0] data1_q;
    logic [DATA_W-1:0] data2_q;
    logic [1:0]        sel_q;
    logic [DATA_W-1:0] rf_q [NREGS];
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    logic              zf_q;
`endif

    logic [1:0]        op_d;
    logic [2:0]        rd_d;
    logic [2:0]        rs1_d;
    logic [2:0]        rs2_d;
    logic [DATA_W-1:0] imm_d;
    logic              accept_d;

    assign op_d     = instr[15:14];
    assign rd_d     = instr[13:11];
    assign rs1_d    = instr[10:8];
    assign rs2_d    = instr[7:5];
    assign imm_d    = DATA_W'(instr[7:0]);
    assign accept_d = instr_valid & ready_q;

    // ready_q mirrors (state_q == IDLE) but stays low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            rd_q      <= '0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            data1_q   <= '0;
            data2_q   <= '0;
            sel_q     <= '0;
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
`ifdef ALU_ISSUE_ZERO_FLAG_EN
            zf_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        ready_q <= 1'b0;
                        if (op_d == OP_LDI) begin
                            rf_q[rd_d] <= imm_d;
                            wb_addr_q  <= rd_d;
                            wb_data_q  <= imm_d;
                            done_q     <= 1'b1;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
                            zf_q       <= (imm_d == '0);
`endif
                            state_q    <= WB;
                        end else begin
                            data1_q <= rf_q[rs1_d];
                            data2_q <= rf_q[rs2_d];
                            sel_q   <= op_d;
                            rd_q    <= rd_d;
                            state_q <= EXEC;
                        end
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                EXEC: begin
                    rf_q[rd_q] <= alu_result;
                    wb_addr_q  <= rd_q;
                    wb_data_q  <= alu_result;
                    done_q     <= 1'b1;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
                    zf_q       <= (alu_result == '0);
`endif
                    state_q    <= WB;
                end
                WB: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign instr_ready = ready_q;
    assign alu_data1   = data1_q;
    assign alu_data2   = data2_q;
    assign alu_sel     = sel_q;
    assign done        = done_q;
    assign wb_addr     = wb_addr_q;
    assign wb_data     = wb_data_q;
    assign dbg_data    = rf_q[dbg_addr];
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    assign zero_flag   = zf_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed vector table, hand-written corner sequences,
// and randomized traffic compared every cycle against a transaction-level reference model.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [15:0] alu_data1;
    logic [15:0] alu_data2;
    logic [1:0]  alu_sel;
    logic [15:0] alu_result;
    logic        done;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    logic        zero_flag;
`endif

    always #5 clk = ~clk;

    // Stand-in for the external combinational ALU.
    always_comb begin
        alu_result = '0;
        case (alu_sel)
            2'b00:   alu_result = alu_data1 + alu_data2;
            2'b01:   alu_result = alu_data1 - alu_data2;
            2'b10:   alu_result = alu_data1 * alu_data2;
            default: alu_result = '0;
        endcase
    end

    alu_issue_ctrl #(.DATA_W(16), .NREGS(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .alu_data1   (alu_data1),
        .alu_data2   (alu_data2),
        .alu_sel     (alu_sel),
        .alu_result  (alu_result),
        .done        (done),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
`ifdef ALU_ISSUE_ZERO_FLAG_EN
        ,
        .zero_flag   (zero_flag)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: architectural registers plus the edge numbers at which
    // the pending write-back lands and the controller becomes ready again.
    logic [15:0] m_rf [8];
    int          cyc;
    int          done_edge;
    int          ready_from;
    logic        m_ready_vis;
    logic        pend_valid;
    logic [2:0]  pend_addr;
    logic [15:0] pend_data;
    logic [15:0] e_d1, e_d2;
    logic [1:0]  e_sel;
    logic        e_done;
    logic [2:0]  e_wba;
    logic [15:0] e_wbd;
    logic        e_zf;
    logic        m_acc;

    function automatic logic [15:0] ref_alu(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] full;
        case (op)
            2'b00:   full = 32'(a) + 32'(b);
            2'b01:   full = 32'(a) - 32'(b);
            2'b10:   full = 32'(a) * 32'(b);
            default: full = '0;
        endcase
        return full[15:0];
    endfunction

    function automatic logic [15:0] mk_alu(input logic [1:0] op, input logic [2:0] rd,
                                           input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 5'b0};
    endfunction

    function automatic logic [15:0] mk_ldi(input logic [2:0] rd, input logic [7:0] imm);
        return {2'b11, rd, 3'b0, imm};
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 8; i++) m_rf[i] = '0;
        done_edge   = -100;
        pend_valid  = 1'b0;
        e_d1 = '0; e_d2 = '0; e_sel = '0;
        e_done = 1'b0; e_wba = '0; e_wbd = '0; e_zf = 1'b0;
        m_ready_vis = 1'b0;
        ready_from  = cyc + 1;
        m_acc       = 1'b0;
    endtask

    task automatic model_edge();
        logic [1:0] op;
        logic [2:0] rd, rs1, rs2;
        cyc++;
        m_acc = 1'b0;
        if (!rst_n) begin
            m_reset();
            return;
        end
        if (instr_valid && m_ready_vis) begin
            m_acc = 1'b1;
            op  = instr[15:14];
            rd  = instr[13:11];
            rs1 = instr[10:8];
            rs2 = instr[7:5];
            if (op == 2'b11) begin
                m_rf[rd]   = {8'h00, instr[7:0]};
                e_wba      = rd;
                e_wbd      = {8'h00, instr[7:0]};
                e_zf       = (instr[7:0] == 8'h00);
                done_edge  = cyc;
                ready_from = cyc + 1;
            end else begin
                e_d1       = m_rf[rs1];
                e_d2       = m_rf[rs2];
                e_sel      = op;
                pend_valid = 1'b1;
                pend_addr  = rd;
                pend_data  = ref_alu(op, m_rf[rs1], m_rf[rs2]);
                done_edge  = cyc + 1;
                ready_from = cyc + 2;
            end
        end else if (pend_valid && cyc == done_edge) begin
            m_rf[pend_addr] = pend_data;
            e_wba      = pend_addr;
            e_wbd      = pend_data;
            e_zf       = (pend_data == 16'h0000);
            pend_valid = 1'b0;
        end
        e_done      = (cyc == done_edge);
        m_ready_vis = (cyc >= ready_from);
    endtask

    task automatic check_all();
        chk("instr_ready", instr_ready, m_ready_vis);
        chk("done", done, e_done);
        chk("wb_addr", wb_addr, e_wba);
        chk("wb_data", wb_data, e_wbd);
        chk("alu_data1", alu_data1, e_d1);
        chk("alu_data2", alu_data2, e_d2);
        chk("alu_sel", alu_sel, e_sel);
        chk("dbg_data", dbg_data, m_rf[dbg_addr]);
`ifdef ALU_ISSUE_ZERO_FLAG_EN
        chk("zero_flag", zero_flag, e_zf);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!instr_ready && k < 10) begin
            step();
            k++;
        end
        chk("ready_wait", instr_ready, 1'b1);
    endtask

    task automatic issue(input logic [15:0] ins, output int lat);
        wait_ready();
        instr_valid = 1'b1;
        instr       = ins;
        step();
        instr_valid = 1'b0;
        instr       = 16'($urandom);
        lat = 0;
        while (!done && lat < 10) begin
            step();
            lat++;
        end
    endtask

    typedef struct {
        logic [15:0] ins;
        logic [2:0]  exp_addr;
        logic [15:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int lat;
        int dones;
        int acc_idx;
        logic [15:0] bp_seq [3];

        cyc = 0;
        rst_n = 1'b0;
        instr_valid = 1'b0;
        instr = '0;
        dbg_addr = '0;
        m_reset();

        vecs[0] = '{mk_ldi(3'd1, 8'h05),             3'd1, 16'h0005, 0};
        vecs[1] = '{mk_ldi(3'd2, 8'h03),             3'd2, 16'h0003, 0};
        vecs[2] = '{mk_alu(2'b00, 3'd3, 3'd1, 3'd2), 3'd3, 16'h0008, 1};
        vecs[3] = '{mk_alu(2'b01, 3'd4, 3'd2, 3'd1), 3'd4, 16'hFFFE, 1};
        vecs[4] = '{mk_ldi(3'd5, 8'h10),             3'd5, 16'h0010, 0};
        vecs[5] = '{mk_alu(2'b10, 3'd5, 3'd5, 3'd5), 3'd5, 16'h0100, 1};
        vecs[6] = '{mk_alu(2'b10, 3'd5, 3'd5, 3'd5), 3'd5, 16'h0000, 1};
        vecs[7] = '{mk_ldi(3'd7, 8'hFF),             3'd7, 16'h00FF, 0};
        vecs[8] = '{mk_alu(2'b00, 3'd6, 3'd7, 3'd7), 3'd6, 16'h01FE, 1};
        vecs[9] = '{mk_alu(2'b01, 3'd0, 3'd0, 3'd7), 3'd0, 16'hFF01, 1};

        // Reset held for three edges, then release.
        #1;
        chk("rst_ready_async", instr_ready, 1'b0);
        for (int i = 0; i < 3; i++) step();
        chk("rst_done", done, 1'b0);
        chk("rst_d1", alu_data1, 16'h0);
        chk("rst_d2", alu_data2, 16'h0);
        chk("rst_sel", alu_sel, 2'b00);
        for (int a = 0; a < 8; a++) begin
            dbg_addr = 3'(a);
            #1;
            chk("rst_dbg", dbg_data, 16'h0);
        end
        rst_n = 1'b1;
        step();
        chk("ready_after_release", instr_ready, 1'b1);

        // Directed vectors.
        for (int v = 0; v < 10; v++) begin
            dbg_addr = vecs[v].exp_addr;
            issue(vecs[v].ins, lat);
            chk("vec_latency", 32'(lat), 32'(vecs[v].exp_lat));
            chk("vec_done", done, 1'b1);
            chk("vec_wb_addr", wb_addr, vecs[v].exp_addr);
            chk("vec_wb_data", wb_data, vecs[v].exp_data);
            chk("vec_dbg_new", dbg_data, vecs[v].exp_data);
`ifdef ALU_ISSUE_ZERO_FLAG_EN
            chk("vec_zero_flag", zero_flag, vecs[v].exp_data == 16'h0);
`endif
            step();
            chk("vec_done_pulse_end", done, 1'b0);
        end

        // Reset during EXEC of ADD r6: instruction abandoned.
        wait_ready();
        instr_valid = 1'b1;
        instr = mk_alu(2'b00, 3'd6, 3'd1, 3'd2);
        step();
        instr_valid = 1'b0;
        dbg_addr = 3'd6;
        rst_n = 1'b0;
        m_reset();
        #1;
        check_all();
        chk("midrst_done", done, 1'b0);
        chk("midrst_r6", dbg_data, 16'h0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("midrst_ready", instr_ready, 1'b1);
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (done) dones++;
        end
        chk("midrst_no_done", 32'(dones), 32'd0);
        chk("midrst_r6_stays", dbg_data, 16'h0);

        // Backpressure: valid held high over back-to-back ADDs.
        issue(mk_ldi(3'd1, 8'h05), lat);
        issue(mk_ldi(3'd2, 8'h03), lat);
        wait_ready();
        bp_seq[0] = mk_alu(2'b00, 3'd3, 3'd1, 3'd2);
        bp_seq[1] = mk_alu(2'b00, 3'd4, 3'd3, 3'd2);
        bp_seq[2] = mk_alu(2'b00, 3'd5, 3'd4, 3'd3);
        acc_idx = 0;
        dones = 0;
        instr_valid = 1'b1;
        instr = bp_seq[0];
        dbg_addr = 3'd5;
        for (int i = 0; i < 9; i++) begin
            step();
            if (done) dones++;
            if (m_acc) begin
                acc_idx++;
                if (acc_idx < 3) instr = bp_seq[acc_idx];
                else instr_valid = 1'b0;
            end
            if (i == 0 || i == 1) chk("bp_ready_low", instr_ready, 1'b0);
        end
        instr_valid = 1'b0;
        chk("bp_done_count", 32'(dones), 32'd3);
        chk("bp_r5", dbg_data, 16'h0013);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            instr_valid = ($urandom_range(0, 9) < 6);
            instr       = 16'($urandom);
            dbg_addr    = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 249) == 0) begin
                rst_n = 1'b0;
                m_reset();
                #1;
                check_all();
            end else begin
                rst_n = 1'b1;
            end
            step();
        end
        rst_n = 1'b1;
        instr_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Issue/writeback controller sitting directly upstream and downstream of the 16-bit combinational ALU (SUM/SUB/MUL, sel 00/01/10).
- Accepts one instruction per valid/ready handshake and reads operands from an internal 8x16 register file.
- Drives the ALU's data1/data2/sel from registers, then captures the ALU result back into the register file.
- Forms the execute core of the small CPU; the fetch logic sits upstream.

Parameters:
- DATA_W, 16, operand/result width; must match the ALU.
- NREGS, 8, register-file depth; register address width is 3 bits.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- instr_valid  input  1  instruction present on instr
- instr  input  16  [15:14] op, [13:11] rd, [10:8] rs1, [7:5] rs2, [7:0] imm8 (LDI only)
- instr_ready  output  1  controller can accept an instruction
- alu_data1  output  DATA_W  registered operand A to ALU
- alu_data2  output  DATA_W  registered operand B to ALU
- alu_sel  output  2  registered ALU op select
- alu_result  input  DATA_W  combinational ALU result
- done  output  1  one-cycle pulse: write-back completed
- wb_addr  output  3  register written on the done cycle
- wb_data  output  DATA_W  value written on the done cycle
- dbg_addr  input  3  debug read address
- dbg_data  output  DATA_W  combinational rf[dbg_addr]

Behaviour:
- Reset is asynchronous, active-low. While rst_n=0:
  - state=IDLE, all 8 registers=0
  - alu_data1=alu_data2=0, alu_sel=00
  - done=0, wb_addr=0, wb_data=0
  - instr_ready=0 while in reset, 1 from the first clock after release
- Opcodes: 00 ADD, 01 SUB, 10 MUL (each passed unchanged as alu_sel), 11 LDI.
- FSM states: IDLE, EXEC, WB.
- instr_ready = (state==IDLE). An instruction is accepted on an edge where instr_valid & instr_ready.
- IDLE, accept ALU op (edge N):
  - latch alu_data1<=rf[rs1], alu_data2<=rf[rs2], alu_sel<=op, rd into an internal register
  - go to EXEC
- EXEC (cycle N+1):
  - ALU inputs stable; alu_result is valid combinationally
  - at edge N+1: rf[rd]<=alu_result, wb_addr<=rd, wb_data<=alu_result, done<=1; go to WB
- IDLE, accept LDI (edge N):
  - rf[rd]<={8'h00,imm8}, wb_addr<=rd, wb_data<=zero-extended imm8, done<=1; go to WB
  - alu_* outputs hold their previous values
- WB (one cycle): done=1. Next edge: done<=0, go to IDLE.
- Latency and throughput:
  - ALU op: done is visible 2 cycles after accept; next accept possible 3 edges after the previous one.
  - LDI: done visible 1 cycle after accept; next accept 2 edges later.
- Arithmetic:
  - results are truncated to DATA_W by the ALU and stored unmodified
  - no overflow detection; SUB wraps modulo 2^16
- Operand hazards:
  - none possible, since a new instruction is only accepted after write-back
  - rs1==rs2==rd is legal; the old value is read and the new value is written
- instr_valid while not ready: ignored; the instruction is not consumed and the upstream stage must hold it.
- instr_valid deasserting in IDLE is legal; there is no stale acceptance.
- alu_* outputs hold their last value when idle (no toggling).
- dbg_data:
  - reflects the register contents after the latest edge
  - reading rd during WB returns the new value
- Reset mid-operation (EXEC or WB): instruction is abandoned, no further write-back, all state returns to reset values.

Optional Feature:
- Macro: ALU_ISSUE_ZERO_FLAG_EN
- When defined:
  - adds output port zero_flag (1 bit), reset 0
  - updated on every write-back edge to (written value == 0), for both ALU ops and LDI
  - holds its value otherwise
- When undefined: port and logic are absent; the rest of the behaviour is unchanged.

Test Plan:
- Reset then idle:
  - rst_n low 3 cycles, release -> instr_ready=1 the next cycle
  - done=0, alu_data1=alu_data2=0, alu_sel=00
  - dbg_data=0 for all 8 addresses
- LDI r1,0x05 then LDI r2,0x03:
  - each -> done pulse 1 cycle after accept, wb_addr=1/2, wb_data=0x0005/0x0003
  - dbg r1=5, r2=3
- ADD r3,r1,r2 (r1=5, r2=3):
  - EXEC cycle: alu_data1=5, alu_data2=3, alu_sel=00
  - done 2 cycles after accept with wb_data=0x0008; SUB r4,r2,r1 -> r4=0xFFFE
- MUL r5,r5,r5 with r5=0x0100 -> r5=0x0000 (truncated); with the flag macro enabled, zero_flag=1.
- Backpressure:
  - hold instr_valid=1 with back-to-back ADDs -> instr_ready low during EXEC/WB
  - each instruction accepted exactly once; accepts spaced by 3 edges
- Reset asserted during EXEC of ADD r6:
  - no done pulse, r6 stays 0, instr_ready=1 after release
